// File: rtl/regop_sequencer_pkg.sv
// Shared definitions for the R-type register-operation sequencer:
// state encoding, ALU operation codes, R-type opcode/funct7 constants
// and the decoded-instruction record passed from the decoder to the FSM.
package regop_sequencer_pkg;

    // Sequencer states, one clock each.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_DONE,
        ST_ERR
    } state_t;

    // Major opcode of every register-register ALU instruction.
    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

    // The two funct7 values that select an ALU operation.
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // ALU operation codes, formed as {instr[30], funct3}.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // Everything the sequencer needs to know about one instruction.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu_op;
        logic       legal;
    } decode_t;

    // True when the code names an operation the ALU actually implements.
    function automatic logic is_supported_alu_op(input logic [3:0] op);
        case (op)
            ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
            ALU_SRL, ALU_OR, ALU_AND, ALU_SUB, ALU_SRA: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regop_sequencer_rtype_decoder.sv
// Purely combinational R-type field extractor and legality check.
// An instruction is legal when it carries the R-type opcode, a funct7 of
// either base or alternate form, and the resulting {instr[30], funct3}
// code is one the ALU implements (which limits the alternate funct7 to
// SUB and SRA).
module rtype_decoder
    import regop_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     fields
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       funct7_ok;

    assign opcode    = instr[6:0];
    assign funct7    = instr[31:25];
    assign funct7_ok = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);

    // Slice the register fields, build the ALU code and judge legality.
    always_comb begin
        fields        = '0;
        fields.rs1    = instr[19:15];
        fields.rs2    = instr[24:20];
        fields.rd     = instr[11:7];
        fields.alu_op = {instr[30], instr[14:12]};
        fields.legal  = (opcode == OPCODE_RTYPE) && funct7_ok
                        && is_supported_alu_op({instr[30], instr[14:12]});
    end

endmodule

// File: rtl/regop_sequencer.sv
// Multi-cycle sequencer for RISC-V R-type instructions. An accepted
// instruction walks DECODE -> READ -> EXEC -> WB -> DONE, producing one
// strobe per stage for the register array and ALU datapath; a rejected
// instruction goes DECODE -> ERR and is dropped. The decoded fields are
// captured at acceptance so the address and ALU_OP outputs come straight
// from flops and stay put until the next instruction is taken.
module regop_sequencer
    import regop_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  R_Addr_A,
    output logic [4:0]  R_Addr_B,
    output logic [4:0]  W_Addr,
    output logic [3:0]  ALU_OP,
    output logic        Reg_Write,
    output logic        rr_en,
    output logic        f_en,
    output logic        wb_en,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_t  state;
    state_t  state_next;
    decode_t dec_in;
    decode_t dec_q;
    logic    accept;

    rtype_decoder u_decoder (
        .instr  (instr),
        .fields (dec_in)
    );

    assign accept = instr_valid && (state == ST_IDLE);

    // State register; reset drops straight back to IDLE at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Hold the decoded instruction from acceptance until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= '0;
        end else if (accept) begin
            dec_q <= dec_in;
        end
    end

    // Next-state selection and per-state strobes.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        busy        = 1'b1;
        rr_en       = 1'b0;
        f_en        = 1'b0;
        wb_en       = 1'b0;
        Reg_Write   = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = dec_q.legal ? ST_READ : ST_ERR;
            end
            ST_READ: begin
                rr_en      = 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                f_en       = 1'b1;
                state_next = ST_WB;
            end
            ST_WB: begin
                wb_en      = 1'b1;
                Reg_Write  = (dec_q.rd != 5'd0);
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                illegal    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign R_Addr_A = dec_q.rs1;
    assign R_Addr_B = dec_q.rs2;
    assign W_Addr   = dec_q.rd;
    assign ALU_OP   = dec_q.alu_op;

endmodule

// File: tb/tb_regop_sequencer.sv
// Self-checking bench for regop_sequencer: a cycle-offset model of the
// instruction lifecycle is compared against every output on every falling
// clock edge, directed cases pin known encodings, then random traffic with
// occasional asynchronous resets runs against the same model.
module tb_regop_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        instr_ready;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [4:0]  W_Addr;
    logic [3:0]  ALU_OP;
    logic        Reg_Write;
    logic        rr_en;
    logic        f_en;
    logic        wb_en;
    logic        busy;
    logic        done;
    logic        illegal;

    int compared = 0;
    int mismatched = 0;

    // Model state: cycles since acceptance (0 = idle) and captured fields.
    int         m_phase = 0;
    logic       m_legal = 1'b0;
    logic [4:0] m_rs1 = 5'd0;
    logic [4:0] m_rs2 = 5'd0;
    logic [4:0] m_rd = 5'd0;
    logic [3:0] m_op = 4'd0;

    regop_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .R_Addr_A    (R_Addr_A),
        .R_Addr_B    (R_Addr_B),
        .W_Addr      (W_Addr),
        .ALU_OP      (ALU_OP),
        .Reg_Write   (Reg_Write),
        .rr_en       (rr_en),
        .f_en        (f_en),
        .wb_en       (wb_en),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Offer one instruction for a single cycle while the DUT sits in IDLE.
    task automatic apply_stimulus(input logic [31:0] word);
        @(posedge clk);
        #1;
        instr_valid = 1'b1;
        instr       = word;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Reference lifecycle: accept in idle, then legal instructions finish
    // five cycles after acceptance and illegal ones two cycles after.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_legal = 1'b0;
            m_rs1   = 5'd0;
            m_rs2   = 5'd0;
            m_rd    = 5'd0;
            m_op    = 4'd0;
        end else if (m_phase == 0) begin
            if (instr_valid) begin
                m_rs1   = instr[19:15];
                m_rs2   = instr[24:20];
                m_rd    = instr[11:7];
                m_op    = {instr[30], instr[14:12]};
                m_legal = (instr[6:0] == 7'h33) &&
                          ((instr[31:25] == 7'h00) ||
                           ((instr[31:25] == 7'h20) &&
                            ((instr[14:12] == 3'd0) || (instr[14:12] == 3'd5))));
                m_phase = 1;
            end
        end else begin
            m_phase = m_phase + 1;
            if ((m_legal && m_phase > 5) || (!m_legal && m_phase > 2)) begin
                m_phase = 0;
            end
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        logic e_wb;
        e_wb = m_legal && (m_phase == 4);
        check_output("instr_ready", 32'(instr_ready), 32'(m_phase == 0));
        check_output("busy",        32'(busy),        32'(m_phase != 0));
        check_output("rr_en",       32'(rr_en),       32'(m_legal && (m_phase == 2)));
        check_output("f_en",        32'(f_en),        32'(m_legal && (m_phase == 3)));
        check_output("wb_en",       32'(wb_en),       32'(e_wb));
        check_output("Reg_Write",   32'(Reg_Write),   32'(e_wb && (m_rd != 5'd0)));
        check_output("done",        32'(done),        32'(m_legal && (m_phase == 5)));
        check_output("illegal",     32'(illegal),     32'(!m_legal && (m_phase == 2)));
        check_output("R_Addr_A",    32'(R_Addr_A),    32'(m_rs1));
        check_output("R_Addr_B",    32'(R_Addr_B),    32'(m_rs2));
        check_output("W_Addr",      32'(W_Addr),      32'(m_rd));
        check_output("ALU_OP",      32'(ALU_OP),      32'(m_op));
    end

    // Directed cases pinning known encodings, then randomized traffic.
    initial begin
        logic [6:0] f7;
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] f3;

        #12;
        check_output("lit_reset_ready", 32'(instr_ready), 32'd1);
        check_output("lit_reset_busy",  32'(busy),        32'd0);
        check_output("lit_reset_addr",  32'({R_Addr_A, R_Addr_B, W_Addr}), 32'd0);
        rst_n = 1'b1;

        // add x3,x1,x2
        apply_stimulus(32'h002081B3);
        @(negedge clk);
        check_output("lit_add_A",  32'(R_Addr_A), 32'd1);
        check_output("lit_add_B",  32'(R_Addr_B), 32'd2);
        check_output("lit_add_W",  32'(W_Addr),   32'd3);
        check_output("lit_add_op", 32'(ALU_OP),   32'd0);
        @(negedge clk);
        check_output("lit_add_rr", 32'(rr_en), 32'd1);
        @(negedge clk);
        check_output("lit_add_f",  32'(f_en),  32'd1);
        @(negedge clk);
        check_output("lit_add_wb", 32'({wb_en, Reg_Write}), 32'b11);
        @(negedge clk);
        check_output("lit_add_done", 32'(done), 32'd1);

        // sub x0,x1,x2: write to x0 is suppressed
        apply_stimulus(32'h40208033);
        @(negedge clk);
        check_output("lit_sub_op", 32'(ALU_OP), 32'd8);
        repeat (3) @(negedge clk);
        check_output("lit_sub_wb", 32'({wb_en, Reg_Write}), 32'b10);
        @(negedge clk);
        check_output("lit_sub_done", 32'(done), 32'd1);

        // funct7=0100000 with funct3=001 is rejected
        apply_stimulus(32'h40209033);
        repeat (2) @(negedge clk);
        check_output("lit_bad_f7_illegal", 32'(illegal), 32'd1);
        check_output("lit_bad_f7_strobes", 32'({rr_en, f_en, wb_en, Reg_Write}), 32'd0);

        // I-type opcode is rejected
        apply_stimulus(32'h00208013);
        repeat (2) @(negedge clk);
        check_output("lit_itype_illegal", 32'(illegal), 32'd1);

        // Reset asserted while in EXEC
        apply_stimulus(32'h002081B3);
        repeat (3) @(negedge clk);
        check_output("lit_exec_f", 32'(f_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("lit_rst_ready", 32'(instr_ready), 32'd1);
        check_output("lit_rst_busy",  32'({busy, f_en}), 32'd0);
        check_output("lit_rst_addr",  32'({R_Addr_A, ALU_OP}), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // add x5,x6,x7 runs normally after the reset
        apply_stimulus({7'b0, 5'd7, 5'd6, 3'b000, 5'd5, 7'b0110011});
        repeat (4) @(negedge clk);
        check_output("lit_after_rst_wb", 32'({wb_en, Reg_Write}), 32'b11);
        @(negedge clk);
        check_output("lit_after_rst_done", 32'(done), 32'd1);

        // Back-to-back with instr_valid held high and instr changing while busy
        @(posedge clk);
        #1;
        instr_valid = 1'b1;
        instr       = 32'h002081B3;
        @(posedge clk);
        #1;
        instr = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        check_output("lit_b2b_hold_A", 32'(R_Addr_A), 32'd1);
        instr = {7'b0, 5'd5, 5'd4, 3'b100, 5'd9, 7'b0110011};
        repeat (3) @(negedge clk);
        check_output("lit_b2b_done", 32'(done), 32'd1);
        @(negedge clk);
        check_output("lit_b2b_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        check_output("lit_b2b_busy", 32'(busy),   32'd1);
        check_output("lit_b2b_W",    32'(W_Addr), 32'd9);
        check_output("lit_b2b_op",   32'(ALU_OP), 32'd4);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst_n       = ($urandom_range(0, 149) != 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            f3  = 3'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            rd  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) begin
                rd = 5'd0;
            end
            case ($urandom_range(0, 4))
                0, 1: f7 = 7'h00;
                2: begin
                    f7 = 7'h20;
                    f3 = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b101;
                end
                3:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            op    = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h33;
            instr = {f7, rs2, rs1, f3, rd, op};
        end

        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        instr_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
